// File: rtl/dm_pkg.sv
// Shared definitions for the MEM-stage data-memory access controller.
package dm_pkg;

  typedef enum logic [1:0] {
    LS_NONE = 2'b00,
    LS_WORD = 2'b01,
    LS_HALF = 2'b10,
    LS_BYTE = 2'b11
  } ls_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_CPU_RD   = 2'b01,
    ST_CPU_DONE = 2'b10,
    ST_DBG_RD   = 2'b11
  } state_e;

  function automatic logic [3:0] lane_mask(input ls_e size, input logic [1:0] lo);
    case (size)
      LS_WORD: lane_mask = 4'b1111;
      LS_HALF: lane_mask = lo[1] ? 4'b1100 : 4'b0011;
      LS_BYTE: lane_mask = 4'b0001 << lo;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Byte-lane steering: store enables/replication and sub-word load extraction/extension.
module dm_lane_align
  import dm_pkg::*;
(
  input  ls_e         st_size_i,
  input  logic [1:0]  st_lo_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  st_we_o,
  output logic [31:0] st_data_o,
  input  ls_e         ld_size_i,
  input  logic [1:0]  ld_lo_i,
  input  logic        ld_ext_i,
  input  logic [31:0] ld_raw_i,
  output logic [31:0] ld_data_o
);

  logic [15:0] ld_half;
  logic [7:0]  ld_byte;

  assign st_we_o = lane_mask(st_size_i, st_lo_i);

  always_comb begin
    case (st_size_i)
      LS_HALF: st_data_o = {2{st_data_i[15:0]}};
      LS_BYTE: st_data_o = {4{st_data_i[7:0]}};
      default: st_data_o = st_data_i;
    endcase
  end

  assign ld_half = ld_lo_i[1] ? ld_raw_i[31:16] : ld_raw_i[15:0];
  assign ld_byte = ld_raw_i[{ld_lo_i, 3'b000} +: 8];

  always_comb begin
    case (ld_size_i)
      LS_HALF: ld_data_o = {{16{ld_ext_i & ld_half[15]}}, ld_half};
      LS_BYTE: ld_data_o = {{24{ld_ext_i & ld_byte[7]}}, ld_byte};
      default: ld_data_o = ld_raw_i;
    endcase
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// Single-port SRAM sequencer for the MEM stage: CPU/debug arbitration, load FSM, stall generation.
module dm_access_ctrl
  import dm_pkg::*;
#(
  parameter int unsigned AW       = 10,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [1:0]    cpu_ls_bit,
  input  logic          cpu_mem_write,
  input  logic          cpu_ext_op,
  input  logic [31:0]   cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_stall,
  output logic          cpu_misalign,
  input  logic          dbg_valid,
  input  logic          dbg_write,
  input  logic [31:0]   dbg_addr,
  input  logic [31:0]   dbg_wdata,
  output logic          dbg_ready,
  output logic          dbg_rvalid,
  output logic [31:0]   dbg_rdata,
  output logic          sram_en,
  output logic [3:0]    sram_we,
  output logic [AW-1:0] sram_addr,
  output logic [31:0]   sram_wdata,
  input  logic [31:0]   sram_rdata
);

  localparam int unsigned SW = $clog2(MAX_WAIT + 1);

  state_e        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [1:0]    lo_q, lo_d;
  ls_e           size_q, size_d;
  logic          ext_q, ext_d;
  logic [31:0]   cpu_rdata_q, dbg_rdata_q;
  logic          misalign_q, misalign_d;
  logic          dbg_rvalid_q;
  logic          ld_done, dbg_rd_done, dbg_win;

  ls_e           cpu_size;
  logic          cpu_req, cpu_misal;
  logic [3:0]    st_we;
  logic [31:0]   st_data, ld_data;
  logic          unused_bits;

  assign cpu_size    = ls_e'(cpu_ls_bit);
  assign cpu_req     = (cpu_size != LS_NONE);
  assign cpu_misal   = ((cpu_size == LS_WORD) && (cpu_addr[1:0] != 2'b00)) ||
                       ((cpu_size == LS_HALF) && cpu_addr[0]);
  assign unused_bits = ^{cpu_addr[31:AW+2], dbg_addr[31:AW+2], dbg_addr[1:0]};

  dm_lane_align u_align (
    .st_size_i (cpu_size),
    .st_lo_i   (cpu_addr[1:0]),
    .st_data_i (cpu_wdata),
    .st_we_o   (st_we),
    .st_data_o (st_data),
    .ld_size_i (size_q),
    .ld_lo_i   (lo_q),
    .ld_ext_i  (ext_q),
    .ld_raw_i  (sram_rdata),
    .ld_data_o (ld_data)
  );

  // While reset is high the combinational outputs look like an idle cycle with no request.
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    lo_d        = lo_q;
    size_d      = size_q;
    ext_d       = ext_q;
    misalign_d  = 1'b0;
    ld_done     = 1'b0;
    dbg_rd_done = 1'b0;
    dbg_win     = 1'b0;
    sram_en     = 1'b0;
    sram_we     = '0;
    sram_addr   = cpu_addr[AW+1:2];
    sram_wdata  = st_data;
    cpu_stall   = 1'b0;
    dbg_ready   = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_IDLE: begin
          dbg_win = dbg_valid && (!cpu_req || (starve_q == SW'(MAX_WAIT)));
          if (dbg_win) begin
            dbg_ready  = 1'b1;
            starve_d   = '0;
            cpu_stall  = cpu_req;
            sram_en    = 1'b1;
            sram_addr  = dbg_addr[AW+1:2];
            sram_wdata = dbg_wdata;
            if (dbg_write) sram_we = '1;
            else           state_d = ST_DBG_RD;
          end else if (cpu_req) begin
            if (dbg_valid && (starve_q != SW'(MAX_WAIT))) starve_d = starve_q + 1'b1;
            if (cpu_misal) begin
              misalign_d = 1'b1;
            end else if (cpu_mem_write) begin
              sram_en = 1'b1;
              sram_we = st_we;
            end else begin
              sram_en   = 1'b1;
              lo_d      = cpu_addr[1:0];
              size_d    = cpu_size;
              ext_d     = cpu_ext_op;
              cpu_stall = 1'b1;
              state_d   = ST_CPU_RD;
            end
          end
        end
        ST_CPU_RD: begin
          cpu_stall = 1'b1;
          ld_done   = 1'b1;
          state_d   = ST_CPU_DONE;
        end
        ST_CPU_DONE: state_d = ST_IDLE;
        ST_DBG_RD: begin
          dbg_rd_done = 1'b1;
          cpu_stall   = cpu_req;
          state_d     = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      starve_q     <= '0;
      lo_q         <= '0;
      size_q       <= LS_NONE;
      ext_q        <= 1'b0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
      misalign_q   <= 1'b0;
      dbg_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      lo_q         <= lo_d;
      size_q       <= size_d;
      ext_q        <= ext_d;
      misalign_q   <= misalign_d;
      dbg_rvalid_q <= dbg_rd_done;
      if (ld_done)     cpu_rdata_q <= ld_data;
      if (dbg_rd_done) dbg_rdata_q <= sram_rdata;
    end
  end

  assign cpu_rdata    = cpu_rdata_q;
  assign cpu_misalign = misalign_q;
  assign dbg_rvalid   = dbg_rvalid_q;
  assign dbg_rdata    = dbg_rdata_q;

endmodule
